// File: rtl/pc_sequencer.sv
// Next-PC sequencer: holds the program counter and steps, branches, jumps, calls
// or returns each cycle, with an internal return-address stack for CALL/RET.
module pc_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                OFS_W    = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         Clk,
    input  logic                         Clear,
    input  logic                         Stall,
    input  logic [2:0]                   Op,
    input  logic                         Cond,
    input  logic [OFS_W-1:0]             Offset,
    input  logic [ADDR_W-1:0]            Target,
    output logic [ADDR_W-1:0]            PC,
    output logic                         Redirect,
    output logic [ADDR_W-1:0]            Link_Top,
    output logic [$clog2(DEPTH+1)-1:0]   Stack_Count,
    output logic                         Stack_Full,
    output logic                         Stack_Empty,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_NEXT = 3'b000,
        OP_BR   = 3'b001,
        OP_JMP  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } op_t;

    logic [ADDR_W-1:0] stack_mem [DEPTH];
    logic [CNT_W-1:0]  stack_cnt;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ofs_ext;
    logic [ADDR_W-1:0] br_pc;

    assign seq_pc  = PC + ADDR_W'(1);
    assign ofs_ext = ADDR_W'($signed(Offset));
    assign br_pc   = seq_pc + ofs_ext;

    assign Stack_Count = stack_cnt;
    assign Stack_Full  = (stack_cnt == CNT_W'(DEPTH));
    assign Stack_Empty = (stack_cnt == '0);

    // Top of stack lives at index stack_cnt-1; reads as zero when empty.
    always_comb begin
        Link_Top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stack_cnt == CNT_W'(i + 1)) begin
                Link_Top = stack_mem[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            PC        <= RESET_PC;
            Redirect  <= 1'b0;
            stack_cnt <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (Stall) begin
            Redirect <= 1'b0;
        end else begin
            PC       <= seq_pc;
            Redirect <= 1'b0;
            case (Op)
                OP_BR: begin
                    if (Cond) begin
                        PC       <= br_pc;
                        Redirect <= 1'b1;
                    end
                end
                OP_JMP: begin
                    PC       <= Target;
                    Redirect <= 1'b1;
                end
                OP_CALL: begin
                    PC       <= Target;
                    Redirect <= 1'b1;
                    if (Stack_Full) begin
                        Overflow <= 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (stack_cnt == CNT_W'(i)) begin
                                stack_mem[i] <= seq_pc;
                            end
                        end
                        stack_cnt <= stack_cnt + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    // A RET with nothing to return to falls through as a plain step.
                    if (Stack_Empty) begin
                        Underflow <= 1'b1;
                    end else begin
                        PC        <= Link_Top;
                        Redirect  <= 1'b1;
                        stack_cnt <= stack_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues hand-computed expected state,
// a monitor pops and compares after every active edge.
module tb_pc_sequencer;

    localparam logic [2:0] NEXT = 3'b000, BR = 3'b001, JMP = 3'b010,
                           CALL = 3'b011, RET = 3'b100, ALIAS = 3'b101;

    logic       Clk = 1'b0;
    logic       Clear;
    logic       Stall;
    logic [2:0] Op;
    logic       Cond;
    logic [7:0] Offset;
    logic [7:0] Target;
    logic [7:0] PC;
    logic       Redirect;
    logic [7:0] Link_Top;
    logic [2:0] Stack_Count;
    logic       Stack_Full;
    logic       Stack_Empty;
    logic       Overflow;
    logic       Underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] pc;
        logic       rd;
        logic [2:0] cnt;
        logic [7:0] top;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb_q[$];

    pc_sequencer #(.ADDR_W(8), .OFS_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .Clk(Clk), .Clear(Clear), .Stall(Stall), .Op(Op), .Cond(Cond),
        .Offset(Offset), .Target(Target), .PC(PC), .Redirect(Redirect),
        .Link_Top(Link_Top), .Stack_Count(Stack_Count), .Stack_Full(Stack_Full),
        .Stack_Empty(Stack_Empty), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},    PC, 8'h00);
        chk({tag, "_rd"},    Redirect, 1'b0);
        chk({tag, "_cnt"},   Stack_Count, 3'd0);
        chk({tag, "_empty"}, Stack_Empty, 1'b1);
        chk({tag, "_full"},  Stack_Full, 1'b0);
        chk({tag, "_top"},   Link_Top, 8'h00);
        chk({tag, "_ovf"},   Overflow, 1'b0);
        chk({tag, "_unf"},   Underflow, 1'b0);
    endtask

    task automatic drive(input logic [2:0] op, input logic cond, input logic [7:0] ofs,
                         input logic [7:0] tgt, input logic stall);
        Op = op; Cond = cond; Offset = ofs; Target = tgt; Stall = stall;
    endtask

    task automatic push_exp(input logic [7:0] pc, input logic rd, input logic [2:0] cnt,
                            input logic [7:0] top, input logic ovf, input logic unf);
        exp_t e;
        e.pc = pc; e.rd = rd; e.cnt = cnt; e.top = top; e.ovf = ovf; e.unf = unf;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [2:0] op, input logic cond, input logic [7:0] ofs,
                        input logic [7:0] tgt, input logic stall,
                        input logic [7:0] pc, input logic rd, input logic [2:0] cnt,
                        input logic [7:0] top, input logic ovf, input logic unf);
        @(negedge Clk);
        drive(op, cond, ofs, tgt, stall);
        push_exp(pc, rd, cnt, top, ovf, unf);
    endtask

    // Monitor: the sequencer presents a new state after every active edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc",    PC, e.pc);
            chk("redir", Redirect, e.rd);
            chk("count", Stack_Count, e.cnt);
            chk("top",   Link_Top, e.top);
            chk("full",  Stack_Full, (e.cnt == 3'd4));
            chk("empty", Stack_Empty, (e.cnt == 3'd0));
            chk("ovf",   Overflow, e.ovf);
            chk("unf",   Underflow, e.unf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Clear = 1'b0;
        drive(NEXT, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk_reset_state("por");

        @(negedge Clk);
        Clear = 1'b1;
        push_exp(8'h01, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step(JMP,  1'b0, 8'h00, 8'h22, 1'b0, 8'h22, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(CALL, 1'b1, 8'h00, 8'h50, 1'b0, 8'h50, 1'b1, 3'd1, 8'h23, 1'b0, 1'b0);

        // Mid-run async reset with a JMP pending; first edge after release runs it.
        @(negedge Clk);
        drive(JMP, 1'b0, 8'h00, 8'h40, 1'b0);
        #2 Clear = 1'b0;
        #1 chk_reset_state("rst_async");
        @(posedge Clk);
        #1 chk_reset_state("rst_held");
        @(negedge Clk);
        Clear = 1'b1;
        push_exp(8'h40, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);

        // Branches
        step(JMP, 1'b0, 8'h00, 8'h10, 1'b0, 8'h10, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(BR,  1'b1, 8'hFC, 8'h00, 1'b0, 8'h0D, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(JMP, 1'b0, 8'h00, 8'h10, 1'b0, 8'h10, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(BR,  1'b0, 8'hFC, 8'h77, 1'b0, 8'h11, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

        // Wrap-around
        step(JMP,  1'b0, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(NEXT, 1'b1, 8'h00, 8'h55, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step(JMP,  1'b0, 8'h00, 8'hF0, 1'b0, 8'hF0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(BR,   1'b1, 8'h20, 8'h00, 1'b0, 8'h11, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(ALIAS,1'b1, 8'h20, 8'h99, 1'b0, 8'h12, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

        // Stack fill, overflow, drain
        step(JMP,  1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(CALL, 1'b0, 8'h00, 8'h20, 1'b0, 8'h20, 1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
        step(CALL, 1'b0, 8'h00, 8'h30, 1'b0, 8'h30, 1'b1, 3'd2, 8'h21, 1'b0, 1'b0);
        step(CALL, 1'b0, 8'h00, 8'h40, 1'b0, 8'h40, 1'b1, 3'd3, 8'h31, 1'b0, 1'b0);
        step(CALL, 1'b0, 8'h00, 8'h50, 1'b0, 8'h50, 1'b1, 3'd4, 8'h41, 1'b0, 1'b0);
        step(CALL, 1'b0, 8'h00, 8'h60, 1'b0, 8'h60, 1'b1, 3'd4, 8'h41, 1'b1, 1'b0);
        step(RET,  1'b0, 8'h00, 8'h00, 1'b0, 8'h41, 1'b1, 3'd3, 8'h31, 1'b1, 1'b0);
        step(RET,  1'b1, 8'h00, 8'h00, 1'b0, 8'h31, 1'b1, 3'd2, 8'h21, 1'b1, 1'b0);
        step(RET,  1'b0, 8'h00, 8'h00, 1'b0, 8'h21, 1'b1, 3'd1, 8'h01, 1'b1, 1'b0);
        step(RET,  1'b0, 8'h00, 8'h00, 1'b0, 8'h01, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0);

        // Underflow, sticky
        step(JMP,  1'b0, 8'h00, 8'h33, 1'b0, 8'h33, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0);
        step(RET,  1'b0, 8'h00, 8'h00, 1'b0, 8'h34, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        step(NEXT, 1'b0, 8'h00, 8'h00, 1'b0, 8'h35, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        step(JMP,  1'b0, 8'h00, 8'h36, 1'b0, 8'h36, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1);

        // Stall holds everything and suppresses Redirect
        step(CALL, 1'b0, 8'h00, 8'h80, 1'b1, 8'h36, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        step(CALL, 1'b0, 8'h00, 8'h80, 1'b1, 8'h36, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        step(CALL, 1'b0, 8'h00, 8'h80, 1'b1, 8'h36, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        step(CALL, 1'b0, 8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 3'd1, 8'h37, 1'b1, 1'b1);
        step(RET,  1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 1'b0, 3'd1, 8'h37, 1'b1, 1'b1);
        step(RET,  1'b0, 8'h00, 8'h00, 1'b0, 8'h37, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1);
        step(NEXT, 1'b0, 8'h00, 8'h00, 1'b0, 8'h38, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);

        repeat (3) @(posedge Clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-PC sequencer for the single-issue core. It supersedes the fixed 8-bit registered jump-address adder. It holds the program counter and computes the next value each cycle from a decoded control op: sequential step, conditional PC-relative branch, absolute jump, call or return. Calls and returns use an internal return-address stack. The block sits between the decoder/branch-condition logic and instruction fetch.

Parameters:
ADDR_W, 8, width of PC, Target and return addresses.
OFS_W, 8, width of signed branch offset; must satisfy 2 <= OFS_W <= ADDR_W.
DEPTH, 4, return-address stack entries; must be >= 1.
RESET_PC, 0, PC value after reset (ADDR_W bits).

Ports:
Clk  in  1  clock; all state updates on rising edge.
Clear  in  1  asynchronous, active-low reset; Clear=0 resets immediately.
Stall  in  1  1 = hold all state this cycle (op ignored).
Op  in  3  000 NEXT, 001 BR, 010 JMP, 011 CALL, 100 RET; 101-111 behave as NEXT.
Cond  in  1  branch-taken qualifier for BR only.
Offset  in  OFS_W  signed two's-complement branch offset.
Target  in  ADDR_W  absolute destination for JMP/CALL.
PC  out  ADDR_W  current program counter (registered).
Redirect  out  1  registered; 1 for one cycle after any non-sequential PC update.
Link_Top  out  ADDR_W  top-of-stack return address; 0 when empty.
Stack_Count  out  clog2(DEPTH+1)  number of valid stack entries.
Stack_Full  out  1  Stack_Count == DEPTH.
Stack_Empty  out  1  Stack_Count == 0.
Overflow  out  1  sticky: CALL attempted while full.
Underflow  out  1  sticky: RET attempted while empty.

Behaviour:
- Reset (Clear=0, asynchronous): PC=RESET_PC, Redirect=0, Stack_Count=0, all stack entries=0, Overflow=0, Underflow=0. Derived outputs: Stack_Empty=1, Stack_Full=0, Link_Top=0.
- Reset has priority over everything. Deassertion mid-operation discards any in-flight op; the first active edge after release executes the op then present.
- Latency: 1 cycle. The op sampled at edge N determines PC after edge N.
- Stall=1: PC, stack, flags held; Redirect forced to 0. Stall overrides Op.
- All arithmetic is modulo 2^ADDR_W; no carry-out or saturation.
- Seq = PC + 1, wrapping, so 0xFF becomes 0x00 for ADDR_W=8.
- NEXT: PC <= Seq; Redirect <= 0.
- BR, Cond=1: PC <= PC + 1 + sext(Offset), with Offset sign-extended to ADDR_W; Redirect <= 1.
- BR, Cond=0: behaves as NEXT.
- JMP: PC <= Target; Redirect <= 1.
- CALL, not full: push Seq; Stack_Count+1; PC <= Target; Redirect <= 1.
- CALL, full: no push, no stack change; Overflow <= 1; PC <= Target; Redirect <= 1.
- RET, not empty: PC <= Link_Top; pop; Stack_Count-1; Redirect <= 1.
- RET, empty: Underflow <= 1; PC <= Seq; Redirect <= 0.
- Cond is ignored for every op except BR.
- Stack is LIFO. Link_Top, Stack_Full and Stack_Empty are combinational from registered stack state.
- Overflow and Underflow clear only on reset.

Test Plan:
1. Defaults (ADDR_W=8, OFS_W=8, DEPTH=4, RESET_PC=0); Clear=0 mid-run with Stall=0, Op=JMP, Target=0x40 -> PC=0x00 immediately, Stack_Count=0, Stack_Empty=1, flags 0; after release, next edge gives PC=0x40 and Redirect=1.
2. PC=0x10; BR, Cond=1, Offset=0xFC -> PC=0x0D, Redirect=1. Repeat from PC=0x10 with Cond=0 -> PC=0x11, Redirect=0.
3. Wrap: PC=0xFF; NEXT -> PC=0x00. PC=0xF0; BR, Cond=1, Offset=0x20 -> PC=0x11.
4. From PC=0x00, five CALLs to Targets 0x20, 0x30, 0x40, 0x50, 0x60:
   - After the 4th CALL: Stack_Full=1, Link_Top=0x41.
   - After the 5th CALL: Overflow=1, PC=0x60, Stack_Count=4.
   - Four RETs then give PC=0x41, 0x31, 0x21, 0x01.
5. With the stack empty, RET at PC=0x33 -> PC=0x34, Underflow=1, Redirect=0; Underflow stays 1 across subsequent NEXT cycles.
6. Hold Stall=1 for 3 cycles while Op=CALL, Target=0x80 -> PC, Stack_Count and flags unchanged, Redirect=0. Drop Stall -> call executes on the next edge.
